// File: rtl/apb_lockstep_pkg.sv
// Shared types and helpers for the APB lockstep checker: divergence kinds,
// FSM state encoding and a saturating increment used by all counters.
package apb_lockstep_pkg;

    typedef enum logic [2:0] {
        MK_NONE     = 3'd0,
        MK_READY    = 3'd1,
        MK_SLVERR   = 3'd2,
        MK_RDATA    = 3'd3,
        MK_TIMEOUT  = 3'd4,
        MK_PROTOCOL = 3'd5
    } mismatch_kind_e;

    typedef logic [1:0] state_e;

    localparam state_e ST_IDLE   = 2'd0;
    localparam state_e ST_ACCESS = 2'd1;
    localparam state_e ST_HUNG   = 2'd2;

    // Callers cast in and out of the 64-bit domain so any counter width fits.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] limit);
        return (value >= limit) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/apb_lockstep_cmp.sv
// Combinational compare of every DUT's response against DUT 0; reports which
// fields diverge and the lowest divergent index, READY > SLVERR > RDATA.
module apb_lockstep_cmp #(
    parameter int NUM_DUTS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 1
) (
    input  logic [NUM_DUTS-1:0]            pready,
    input  logic [NUM_DUTS-1:0]            pslverr,
    input  logic [NUM_DUTS*DATA_WIDTH-1:0] prdata,
    output logic                           ready_div,
    output logic                           slverr_div,
    output logic                           rdata_div,
    output logic [IDX_W-1:0]               div_idx
);

    logic [IDX_W-1:0] ready_idx;
    logic [IDX_W-1:0] slverr_idx;
    logic [IDX_W-1:0] rdata_idx;

    // Scanning downwards leaves the lowest differing index in each *_idx.
    always_comb begin
        ready_div  = 1'b0;
        slverr_div = 1'b0;
        rdata_div  = 1'b0;
        ready_idx  = '0;
        slverr_idx = '0;
        rdata_idx  = '0;
        for (int i = NUM_DUTS - 1; i >= 1; i--) begin
            if (pready[i] != pready[0]) begin
                ready_div = 1'b1;
                ready_idx = IDX_W'(i);
            end
            if (pslverr[i] != pslverr[0]) begin
                slverr_div = 1'b1;
                slverr_idx = IDX_W'(i);
            end
            if (prdata[i*DATA_WIDTH +: DATA_WIDTH] != prdata[0 +: DATA_WIDTH]) begin
                rdata_div = 1'b1;
                rdata_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        div_idx = rdata_idx;
        if (ready_div) begin
            div_idx = ready_idx;
        end else if (slverr_div) begin
            div_idx = slverr_idx;
        end
    end

endmodule

// File: rtl/apb_lockstep_checker.sv
// Lockstep checker for NUM_DUTS APB slaves sharing one requester. Optional
// transfer/mismatch counters are built only when APB_LOCKSTEP_CNT_EN is defined.
module apb_lockstep_checker
    import apb_lockstep_pkg::*;
#(
    parameter int NUM_DUTS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [NUM_DUTS-1:0]            PREADY,
    input  logic [NUM_DUTS-1:0]            PSLVERR,
    input  logic [NUM_DUTS*DATA_WIDTH-1:0] PRDATA,
    input  logic                           clear,
    output logic                           mismatch,
    output logic                           mismatch_pulse,
    output logic [2:0]                     mismatch_kind,
    output logic [$clog2(NUM_DUTS)-1:0]    mismatch_dut,
    output logic [ADDR_WIDTH-1:0]          mismatch_addr,
    output logic [CNT_WIDTH-1:0]           xfer_count,
    output logic [CNT_WIDTH-1:0]           mismatch_count,
    output logic [1:0]                     dbg_state
);

    localparam int IDX_W  = $clog2(NUM_DUTS);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic             ready_div;
    logic             slverr_div;
    logic             rdata_div;
    logic [IDX_W-1:0] div_idx;
    logic             all_ready;

    state_e           state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    mismatch_kind_e   event_kind;
    logic             event_valid;
    logic [IDX_W-1:0] event_dut;

    logic                  mismatch_q, mismatch_d;
    logic                  pulse_q, pulse_d;
    mismatch_kind_e        kind_q, kind_d;
    logic [IDX_W-1:0]      dut_q, dut_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    apb_lockstep_cmp #(
        .NUM_DUTS   (NUM_DUTS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_cmp (
        .pready     (PREADY),
        .pslverr    (PSLVERR),
        .prdata     (PRDATA),
        .ready_div  (ready_div),
        .slverr_div (slverr_div),
        .rdata_div  (rdata_div),
        .div_idx    (div_idx)
    );

    assign all_ready = &PREADY;

    // Protocol follower; a lost lockstep parks in HUNG until the requester lets go of PSEL.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        event_kind = MK_NONE;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ST_ACCESS;
                    wait_d  = '0;
                end else if (PSEL && PENABLE) begin
                    event_kind = MK_PROTOCOL;
                end
            end
            ST_ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    event_kind = MK_PROTOCOL;
                    state_d    = ST_IDLE;
                end else if (ready_div) begin
                    event_kind = MK_READY;
                    state_d    = ST_HUNG;
                end else if (all_ready) begin
                    state_d = ST_IDLE;
                    if (slverr_div) begin
                        event_kind = MK_SLVERR;
                    end else if (!PWRITE && rdata_div) begin
                        event_kind = MK_RDATA;
                    end
                end else begin
                    wait_d = WAIT_W'(sat_inc(64'(wait_q), 64'(TIMEOUT)));
                    if (wait_d == WAIT_W'(TIMEOUT)) begin
                        event_kind = MK_TIMEOUT;
                        state_d    = ST_HUNG;
                    end
                end
            end
            ST_HUNG: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign event_valid = (event_kind != MK_NONE);

    always_comb begin
        event_dut = '0;
        if (event_kind == MK_READY || event_kind == MK_SLVERR || event_kind == MK_RDATA) begin
            event_dut = div_idx;
        end
    end

    // A clear coinciding with an event wipes the old record and keeps the new one.
    always_comb begin
        mismatch_d = mismatch_q & ~clear;
        kind_d     = clear ? MK_NONE : kind_q;
        dut_d      = clear ? '0 : dut_q;
        addr_d     = clear ? '0 : addr_q;
        pulse_d    = event_valid;
        if (event_valid) begin
            mismatch_d = 1'b1;
            if (!mismatch_q || clear) begin
                kind_d = event_kind;
                dut_d  = event_dut;
                addr_d = PADDR;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            mismatch_q <= 1'b0;
            pulse_q    <= 1'b0;
            kind_q     <= MK_NONE;
            dut_q      <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            mismatch_q <= mismatch_d;
            pulse_q    <= pulse_d;
            kind_q     <= kind_d;
            dut_q      <= dut_d;
            addr_q     <= addr_d;
        end
    end

    assign mismatch       = mismatch_q;
    assign mismatch_pulse = pulse_q;
    assign mismatch_kind  = kind_q;
    assign mismatch_dut   = dut_q;
    assign mismatch_addr  = addr_q;
    assign dbg_state      = state_q;

`ifdef APB_LOCKSTEP_CNT_EN
    logic                 xfer_done;
    logic [CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;
    logic [CNT_WIDTH-1:0] mismatch_count_q, mismatch_count_d;

    assign xfer_done = (state_q == ST_ACCESS) && PSEL && PENABLE && all_ready;

    always_comb begin
        xfer_count_d     = xfer_count_q;
        mismatch_count_d = mismatch_count_q;
        if (xfer_done) begin
            xfer_count_d = CNT_WIDTH'(sat_inc(64'(xfer_count_q), 64'({CNT_WIDTH{1'b1}})));
        end
        if (event_valid) begin
            mismatch_count_d = CNT_WIDTH'(sat_inc(64'(mismatch_count_q), 64'({CNT_WIDTH{1'b1}})));
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            xfer_count_q     <= '0;
            mismatch_count_q <= '0;
        end else begin
            xfer_count_q     <= xfer_count_d;
            mismatch_count_q <= mismatch_count_d;
        end
    end

    assign xfer_count     = xfer_count_q;
    assign mismatch_count = mismatch_count_q;
`else
    assign xfer_count     = '0;
    assign mismatch_count = '0;
`endif

endmodule

// File: doc/apb_lockstep_checker.md
# apb_lockstep_checker

Synthesizable lockstep checker for `NUM_DUTS` APB slave instances that share one requester. It follows the shared request with a small protocol FSM and compares every DUT's `PREADY` each access cycle. At transfer completion it compares `PSLVERR`, and `PRDATA` on reads, against DUT 0. It latches the first divergence, counts transfers and mismatches, and is the simulation/emulation successor to the two-instance formal equivalence properties in the equivalence bench.

## Interface
- `NUM_DUTS`, 2: number of compared instances (≥2); DUT 0 is the golden copy
- `DATA_WIDTH`, 32: `PRDATA` width (multiple of 8)
- `ADDR_WIDTH`, 16: `PADDR` width
- `TIMEOUT`, 16: maximum ACCESS cycles before a hang is declared (≥1)
- `CNT_WIDTH`, 16: counter width
- `PCLK`  in  1  clock
- `PRESET`  in  1  reset, asynchronous, active-high
- `PSEL`, `PENABLE`, `PWRITE`  in  1  shared request
- `PADDR`  in  `ADDR_WIDTH`  shared address
- `PREADY`  in  `NUM_DUTS`  per-DUT ready
- `PSLVERR`  in  `NUM_DUTS`  per-DUT error
- `PRDATA`  in  `NUM_DUTS*DATA_WIDTH`  per-DUT read data; DUT i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`
- `clear`  in  1  synchronous clear of sticky capture
- `mismatch`  out  1  sticky: any divergence since reset/clear
- `mismatch_pulse`  out  1  one-cycle pulse per detected divergence
- `mismatch_kind`  out  3  first divergence: 0 NONE, 1 READY, 2 SLVERR, 3 RDATA, 4 TIMEOUT, 5 PROTOCOL
- `mismatch_dut`  out  `$clog2(NUM_DUTS)`  lowest-index DUT differing from DUT 0 (0 for TIMEOUT/PROTOCOL)
- `mismatch_addr`  out  `ADDR_WIDTH`  `PADDR` of the first divergent transfer
- `xfer_count`, `mismatch_count`  out  `CNT_WIDTH`  completed transfers / detected divergences

## Operation
- **IDLE**
  - `PSEL & !PENABLE` → ACCESS (setup sampled).
  - `PSEL & PENABLE` → PROTOCOL event; stay IDLE.
- **ACCESS**
  - The request must hold `PSEL & PENABLE`; otherwise → PROTOCOL event, go to IDLE.
  - `PREADY` not all equal → READY event, go to HUNG.
  - `PREADY` all 1 → completion: `xfer_count` increments.
    - Any `PSLVERR[i] != PSLVERR[0]` → SLVERR event.
    - Else, if `!PWRITE` and any `PRDATA[i] != PRDATA[0]` → RDATA event.
    - Go to IDLE.
  - `PREADY` all 0 → wait counter increments; on reaching `TIMEOUT` → TIMEOUT event, go to HUNG.
- **HUNG**: stays until `!PSEL`, then goes to IDLE. No further compares are made; lockstep is lost.
- **Priority**: at most one event per cycle; READY > SLVERR > RDATA. `mismatch_dut` is the lowest divergent index.
- **Capture**
  - An event sets `mismatch` and pulses `mismatch_pulse`.
  - `mismatch_count` increments on every event.
  - `kind`/`dut`/`addr` load only while `mismatch == 0`.
- **Clear**
  - `clear` zeroes `mismatch`, `kind`, `dut` and `addr`. Counters are untouched.
  - `clear` and an event in the same cycle: the event is captured.
- **Counters** saturate at all-ones; no wrap.
- **Wait counter** resets on ACCESS entry and saturates at `TIMEOUT`.

## Timing
- All outputs are registered and reset to 0; the FSM resets to IDLE.
- Latency: an event at PCLK edge n is visible on the outputs after edge n+1 (one cycle).
- Zero-wait transfer: setup cycle, then ACCESS with all `PREADY = 1`. Minimum two cycles per transfer; back-to-back transfers are supported.
- TIMEOUT fires on the `TIMEOUT`-th consecutive all-zero `PREADY` ACCESS cycle.
- `PRESET` mid-transfer: immediate return to reset values. The next transfer must start with a fresh setup; an `ACCESS` phase seen first is PROTOCOL.

## Configuration
- `APB_LOCKSTEP_CNT_EN`
  - Defined: `xfer_count` and `mismatch_count` are implemented as described.
  - Undefined: no counter flops; both outputs are tied to 0. Detection and capture are unchanged.

## Structure
- Package `apb_lockstep_pkg` holds:
  - `mismatch_kind_e` (3-bit enum, values above);
  - `state_e` (IDLE, ACCESS, HUNG);
  - the saturating-increment function.
- Sub-module `apb_lockstep_cmp` is purely combinational.
  - Inputs: `PREADY`/`PSLVERR`/`PRDATA` vectors.
  - Outputs: `ready_div`, `slverr_div`, `rdata_div` flags and the lowest divergent index.
- The top holds the FSM, wait counter, capture registers and counters.

## Test plan
- `NUM_DUTS=3`, read at `0x10`, all DUTs return `0xCAFE_0001` with zero waits → `mismatch = 0`, `xfer_count = 1`.
- Read where DUT 2 returns `0xCAFE_0002` → next cycle `mismatch_pulse = 1`, `kind = 3`, `dut = 2`, `addr = 0x10`, `mismatch_count = 1`.
- Write where `PRDATA` differs but `PSLVERR` matches → no event. Then DUT 1 `PSLVERR = 1` on the next write → `kind = 2`, `dut = 1`.
- `PREADY = 3'b011` in ACCESS → `kind = 1`, FSM in HUNG. Further transfers are ignored until `PSEL` drops; `xfer_count` is unchanged.
- `TIMEOUT=4`, all `PREADY` held 0 → TIMEOUT on the 4th ACCESS cycle. A second event afterwards pulses but leaves `kind = 4`. `clear` in the same cycle as a new RDATA event → `kind = 3`.
- `PENABLE` high with no setup → PROTOCOL (`kind = 5`). `PRESET` mid-ACCESS → all outputs 0 next cycle.
